// File: rtl/timer_pkg.sv
// timer_pkg: shared types for the interval timer.
//   state_t : controller state (IDLE, RUN, HOLD)
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage : timer_pkg

// File: rtl/interval_timer_if.sv
// interval_timer_if: control/status bundle between a control source and
// the interval timer.
//   start, abort, hold, periodic, period[N], prescale[P] : control -> timer
//   busy, done_tick, count[N]                           : timer -> control
//   modport master : control source side
//   modport slave  : timer side
interface interval_timer_if #(
  parameter int N = 8,
  parameter int P = 4
);

  logic         start;
  logic         abort;
  logic         hold;
  logic         periodic;
  logic [N-1:0] period;
  logic [P-1:0] prescale;
  logic         busy;
  logic         done_tick;
  logic [N-1:0] count;

  modport master (
    output start, abort, hold, periodic, period, prescale,
    input  busy, done_tick, count
  );

  modport slave (
    input  start, abort, hold, periodic, period, prescale,
    output busy, done_tick, count
  );

endinterface : interval_timer_if

// File: rtl/interval_timer_prescaler.sv
// interval_timer_prescaler: P-bit divider producing count ticks.
//   clk, reset : clock, synchronous active-high reset
//   en_i       : advance the divider this cycle
//   clr_i      : synchronous clear (wins over en_i)
//   div_i      : divide value minus one; tick every div_i+1 enabled cycles
//   tick_o     : high in the enabled cycle where the divider wraps
module interval_timer_prescaler #(
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [P-1:0] div_i,
  output logic         tick_o
);

  logic [P-1:0] cnt_q, cnt_d;

  // Tick is combinational so the main counter steps in the same cycle
  // the divider wraps; div_i == 0 ticks on every enabled cycle.
  assign tick_o = en_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (en_i)  cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule : interval_timer_prescaler

// File: rtl/interval_timer.sv
// interval_timer: one-shot / periodic interval timer controller.
//   clk, reset : clock, synchronous active-high reset
//   bus        : interval_timer_if slave
//     start     - begin a run (IDLE only); captures period/prescale/periodic
//     abort     - end the run at once, never produces an expiry pulse
//     hold      - freeze counter and prescaler while high
//     busy      - high in RUN or HOLD
//     done_tick - registered one-cycle expiry pulse
//     count     - current main counter value
module interval_timer
  import timer_pkg::*;
#(
  parameter int N = 8,
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         reset,
  interval_timer_if.slave bus
);

  state_t       state_q;
  logic [N-1:0] count_q;
  logic [N-1:0] period_q;
  logic [P-1:0] prescale_q;
  logic         periodic_q;
  logic         done_q;
  logic         busy_q;

  logic         active;
  logic         ps_en;
  logic         ps_clr;
  logic         tick;

  assign active = (state_q != IDLE);

  // Counting is gated purely by the hold level, so every cycle hold is high
  // costs exactly one cycle of run time, whether we sit in RUN or HOLD.
  assign ps_en  = active && !bus.abort && !bus.hold;
  assign ps_clr = (!active && bus.start) || (active && bus.abort);

  interval_timer_prescaler #(.P(P)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en_i   (ps_en),
    .clr_i  (ps_clr),
    .div_i  (prescale_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            period_q   <= bus.period;
            prescale_q <= bus.prescale;
            periodic_q <= bus.periodic;
            count_q    <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN, HOLD: begin
          if (bus.abort) begin
            count_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (bus.hold) begin
            state_q <= HOLD;
          end else begin
            state_q <= RUN;
            if (tick) begin
              if (count_q == period_q) begin
                // Expiry: wrap and pulse; one-shot drops busy on this edge
                // so a start in the very next cycle is accepted.
                count_q <= '0;
                done_q  <= 1'b1;
                if (!periodic_q) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                end
              end else begin
                count_q <= count_q + 1'b1;
              end
            end
          end
        end
        default: begin
          count_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done_tick = done_q;
  assign bus.count     = count_q;

endmodule : interval_timer

// File: tb/tb_interval_timer.sv
module tb_interval_timer;

  localparam int N = 8;
  localparam int P = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  interval_timer_if #(.N(N), .P(P)) bus ();

  interval_timer #(.N(N), .P(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic         rst;
    logic         start;
    logic         abort;
    logic         hold;
    logic         periodic;
    logic [N-1:0] period;
    logic [P-1:0] prescale;
    logic         exp_busy;
    logic         exp_done;
    logic [N-1:0] exp_count;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, sample at +1.
  task automatic cyc(input logic rst, input logic st, input logic ab, input logic hd,
                     input logic pe, input logic [N-1:0] per, input logic [P-1:0] ps);
    @(negedge clk);
    reset        = rst;
    bus.start    = st;
    bus.abort    = ab;
    bus.hold     = hd;
    bus.periodic = pe;
    bus.period   = per;
    bus.prescale = ps;
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic b, input logic d, input logic [N-1:0] c);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".done"}, 32'(bus.done_tick), 32'(d));
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic ab, input logic hd,
                              input logic pe, input int per, input int ps,
                              input logic eb, input logic ed, input int ec);
    vec_t v;
    v.rst = rst; v.start = st; v.abort = ab; v.hold = hd; v.periodic = pe;
    v.period = N'(per); v.prescale = P'(ps);
    v.exp_busy = eb; v.exp_done = ed; v.exp_count = N'(ec);
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.abort = 0; bus.hold = 0; bus.periodic = 0;
    bus.period = '0; bus.prescale = '0;

    //              rst st ab hd pe per ps   busy done cnt
    // reset, then one-shot period=3 prescale=0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 3, 0,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    // periodic period=0: expiry on every tick, then abort
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 9, 3,  1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 9, 3,  1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 0));
    // start while busy and period changed mid-run are ignored
    vecs.push_back(mk(0, 1, 0, 0, 0, 2, 0,  1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 7, 5,  1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0));
    // abort coincident with the final tick: no pulse
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].start, vecs[i].abort, vecs[i].hold,
          vecs[i].periodic, vecs[i].period, vecs[i].prescale);
      chk3($sformatf("vec%0d", i), vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_count);
    end

    // Periodic period=2 prescale=1: tick every 2 cycles, pulse every 6.
    cyc(0, 1, 0, 0, 1, 2, 1);
    chk3("per.t0", 1, 0, 0);
    for (int t = 1; t <= 30; t++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk3($sformatf("per.t%0d", t), 1, (t % 6 == 0), N'((t / 2) % 3));
    end
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk3("per.abort", 0, 0, 0);

    // Hold for 3 cycles mid-run, period=5 prescale=0: expiry moves 6 -> 9.
    cyc(0, 1, 0, 0, 0, 5, 0);
    chk3("hold.t0", 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0); chk3("hold.t1", 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0); chk3("hold.t2", 1, 0, 2);
    for (int t = 3; t <= 5; t++) begin
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk3($sformatf("hold.t%0d", t), 1, 0, 2);
    end
    cyc(0, 0, 0, 0, 0, 0, 0); chk3("hold.t6", 1, 0, 3);
    cyc(0, 0, 0, 0, 0, 0, 0); chk3("hold.t7", 1, 0, 4);
    cyc(0, 0, 0, 0, 0, 0, 0); chk3("hold.t8", 1, 0, 5);
    cyc(0, 0, 0, 0, 0, 0, 0); chk3("hold.t9", 0, 1, 0);

    // Reset mid-run at count=4, then a fresh run behaves as the first one.
    cyc(0, 1, 0, 0, 1, 6, 0);
    chk3("rst.t0", 1, 0, 0);
    for (int t = 1; t <= 4; t++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk3($sformatf("rst.t%0d", t), 1, 0, N'(t));
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk3("rst.applied", 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk3("rst.idle", 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 0); chk3("rst.run0", 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0); chk3("rst.run1", 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0); chk3("rst.run2", 0, 1, 0);
    // start in the cycle done_tick is high is accepted
    cyc(0, 1, 0, 0, 0, 0, 0); chk3("b2b.t0", 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0); chk3("b2b.t1", 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0); chk3("b2b.t2", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_interval_timer

// File: doc/interval_timer.md
# interval_timer

Programmable interval timer controller that sequences an N-bit up-counter through one-shot or periodic timing runs. A prescaler divides clk into count ticks; the controller loads the period, starts, holds, aborts and restarts the counter, and signals each expiry with a one-cycle pulse. It sits between a control source (bus registers or an FSM) and any logic needing programmable delays or periodic strobes.

## Interface
- N, 8: width of period register and main counter
- P, 4: width of prescaler divide value
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate run immediately, no expiry pulse
- hold  in  1  freeze counter and prescaler while high
- periodic  in  1  1 = auto-restart after expiry, 0 = one-shot; captured with start
- period  in  N  terminal count; captured with start
- prescale  in  P  tick divisor minus one; captured with start
- busy  out  1  high in RUN or HOLD
- done_tick  out  1  registered one-cycle expiry pulse
- count  out  N  current main counter value

## Operation
- States: IDLE, RUN, HOLD. Reset: state IDLE, count 0, prescaler 0, done_tick 0, busy 0, captured period/prescale/periodic 0.
- IDLE: start=1 captures period, prescale, periodic; clears count and prescaler; next state RUN. Other inputs ignored.
- RUN: priority abort > hold > counting.
  - abort=1: next state IDLE, count and prescaler cleared, done_tick stays 0 even if expiry coincides.
  - hold=1 (no abort): next state HOLD; count and prescaler unchanged this cycle.
  - Otherwise prescaler advances; tick asserted when prescaler equals captured prescale, prescaler then wraps to 0. prescale=0 gives a tick every cycle.
  - On tick with count < captured period: count + 1.
  - On tick with count == captured period: count wraps to 0, done_tick=1 next cycle; next state RUN if captured periodic, else IDLE.
- HOLD: abort=1 -> IDLE (cleared); hold=0 -> RUN, counting resumes next cycle with no lost or extra ticks; otherwise stay, all values frozen.
- start while RUN/HOLD ignored; changes on period/prescale/periodic while busy have no effect.
- period=0: expiry on every tick. All arithmetic modulo width; count never exceeds captured period.

## Timing
- start sampled at edge k: busy=1 from edge k; count=0 in cycle after edge k.
- Run length, no hold: done_tick high in cycle after edge k + (period+1)*(prescale+1).
- Periodic: done_tick repeats every (period+1)*(prescale+1) cycles, no gap cycle at restart.
- Each HOLD cycle delays expiry by exactly one cycle.
- One-shot: busy falls at the same edge done_tick rises; a start in that cycle is accepted (next run begins).
- abort: busy=0 and count=0 one edge after abort sampled.
- reset mid-run: all outputs to reset values at next edge, done_tick suppressed.

## Structure
- Package timer_pkg: state typedef state_t {IDLE, RUN, HOLD}.
- Sub-module prescaler: P-bit counter with enable, synchronous clear and divide input; outputs tick. Main counter and FSM inline in interval_timer.

## Test plan
- One-shot, period=3, prescale=0, start pulse -> count 0,1,2,3,0; done_tick single pulse 4 cycles after start edge; busy low thereafter.
- Periodic, period=2, prescale=1 -> done_tick every 6 cycles for 5 consecutive periods, count holds each value 2 cycles.
- Hold 3 cycles mid-run (period=5, prescale=0) -> count frozen during hold, expiry delayed exactly 3 cycles.
- abort asserted in same cycle as final tick -> no done_tick, busy=0, count=0 next cycle.
- start while busy and period changed mid-run -> ignored; run completes with originally captured period.
- reset mid-run with count=4 -> count 0, busy 0, done_tick 0 next cycle; subsequent start behaves as first run.
